datamem_arbiter: RTL and testbench

//  Two-requester arbiter/controller in front of the single datamem port (byte-addressed,

---
 rtl/mem_pkg.sv | 24 ++
 rtl/rr_arbiter2.sv | 30 +++
 rtl/datamem_arbiter.sv | 130 +++++++++++++
 tb/tb_datamem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared datamem types: access width encoding and helpers
// used by the arbiter and anything driving the datamem port.
package mem_pkg;

  typedef enum logic [1:0] {
    RW_B    = 2'b00,
    RW_HALF = 2'b01,
    RW_WORD = 2'b10
  } rw_type_e;

  localparam logic [1:0] RW_ILLEGAL = 2'b11;

  function automatic logic [2:0] rw_nbytes(input logic [1:0] t);
    logic [2:0] n;
    unique case (t)
      RW_B:    n = 3'd1;
      RW_HALF: n = 3'd2;
      RW_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the port that did not win
// last time takes priority when both are eligible.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] elig,
  output logic [1:0] gnt
);

  logic last_gnt_q;

  always_comb begin
    gnt = 2'b00;
    unique case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b1;
    end else if (|gnt) begin
      last_gnt_q <= gnt[1];
    end
  end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port front end for the single datamem port: grant,
// alignment/bounds check and registered per-port responses.
module datamem_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_SIZE = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [1:0]  req0_type,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req0_sign_ext,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [1:0]  req1_type,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic        req1_sign_ext,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        mem_write_en,
  output logic [1:0]  mem_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_sign_ext,
  input  logic [31:0] mem_dout
);

  logic [1:0]  rsp_valid_q;
  logic [1:0]  rsp_err_q;
  logic [31:0] rsp_rdata_q [2];

  logic [1:0]  req_v;
  logic [1:0]  rsp_rdy;
  logic [1:0]  elig;
  logic [1:0]  gnt;

  // Reset gates requests so nothing is granted or written while held
  assign req_v   = {req1_valid, req0_valid} & {2{rst_n}};
  assign rsp_rdy = {rsp1_ready, rsp0_ready};
  assign elig    = req_v & (~rsp_valid_q | rsp_rdy);

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .elig  (elig),
    .gnt   (gnt)
  );

  logic        any;
  logic        s_we;
  logic [1:0]  s_type;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_sx;

  assign any     = |gnt;
  assign s_we    = gnt[1] ? req1_we       : req0_we;
  assign s_type  = gnt[1] ? req1_type     : req0_type;
  assign s_addr  = gnt[1] ? req1_addr     : req0_addr;
  assign s_wdata = gnt[1] ? req1_wdata    : req0_wdata;
  assign s_sx    = gnt[1] ? req1_sign_ext : req0_sign_ext;

  logic [2:0] nbytes;
  logic       mis;
  logic       oor;
  logic       err;

  always_comb begin
    nbytes = rw_nbytes(s_type);
    mis    = 1'b0;
    unique case (s_type)
      RW_B:    mis = 1'b0;
      RW_HALF: mis = s_addr[0];
      RW_WORD: mis = |s_addr[1:0];
      default: mis = 1'b1;
    endcase
    oor = {1'b0, s_addr} > (33'(MEM_SIZE) - 33'(nbytes));
    err = mis | oor;
  end

  assign mem_write_en = any & s_we & ~err;
  assign mem_type     = any ? s_type  : RW_WORD;
  assign mem_addr     = any ? s_addr  : 32'd0;
  assign mem_din      = any ? s_wdata : 32'd0;
  assign mem_sign_ext = any & s_sx;

  logic [31:0] ld_data;
  assign ld_data = (!s_we && !err) ? mem_dout : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q    <= 2'b00;
      rsp_err_q      <= 2'b00;
      rsp_rdata_q[0] <= 32'd0;
      rsp_rdata_q[1] <= 32'd0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (gnt[n]) begin
          rsp_valid_q[n] <= 1'b1;
          rsp_err_q[n]   <= err;
          rsp_rdata_q[n] <= ld_data;
        end else if (rsp_rdy[n]) begin
          rsp_valid_q[n] <= 1'b0;
        end
      end
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_err   = rsp_err_q[0];
  assign rsp1_err   = rsp_err_q[1];
  assign rsp0_rdata = rsp_rdata_q[0];
  assign rsp1_rdata = rsp_rdata_q[1];

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter with a behavioural datamem and
// a transaction-level reference model of grants and responses.
module tb_datamem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  rv, rwe, rsx, srdy;
  logic [1:0]  rty [2];
  logic [31:0] rad [2];
  logic [31:0] rwd [2];

  logic        rdy0, rdy1, rspv0, rspv1, er0, er1;
  logic [31:0] rd0, rd1;
  logic        mwe, msx;
  logic [1:0]  mty;
  logic [31:0] mad, mdin, mdout;

  datamem_arbiter #(.MEM_SIZE(512)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rv[0]), .req0_ready(rdy0), .req0_we(rwe[0]),
    .req0_type(rty[0]), .req0_addr(rad[0]), .req0_wdata(rwd[0]),
    .req0_sign_ext(rsx[0]),
    .req1_valid(rv[1]), .req1_ready(rdy1), .req1_we(rwe[1]),
    .req1_type(rty[1]), .req1_addr(rad[1]), .req1_wdata(rwd[1]),
    .req1_sign_ext(rsx[1]),
    .rsp0_valid(rspv0), .rsp0_ready(srdy[0]), .rsp0_rdata(rd0),
    .rsp0_err(er0),
    .rsp1_valid(rspv1), .rsp1_ready(srdy[1]), .rsp1_rdata(rd1),
    .rsp1_err(er1),
    .mem_write_en(mwe), .mem_type(mty), .mem_addr(mad),
    .mem_din(mdin), .mem_sign_ext(msx), .mem_dout(mdout)
  );

  function automatic logic [7:0] initb(int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [31:0] initw(int a);
    return {initb(a + 3), initb(a + 2), initb(a + 1), initb(a)};
  endfunction

  // Behavioural datamem: little-endian, combinational read
  logic       init;
  logic [7:0] dm [512];
  logic [8:0] da;
  logic [31:0] dw;

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 512; i++) dm[i] <= initb(i);
    end else if (mwe) begin
      dm[mad[8:0]] <= mdin[7:0];
      if (mty != 2'b00) dm[mad[8:0] + 9'd1] <= mdin[15:8];
      if (mty == 2'b10) begin
        dm[mad[8:0] + 9'd2] <= mdin[23:16];
        dm[mad[8:0] + 9'd3] <= mdin[31:24];
      end
    end
  end

  always_comb begin
    da = mad[8:0];
    dw = {dm[da + 9'd3], dm[da + 9'd2], dm[da + 9'd1], dm[da]};
    case (mty)
      2'b00:   mdout = msx ? {{24{dw[7]}}, dw[7:0]} : {24'd0, dw[7:0]};
      2'b01:   mdout = msx ? {{16{dw[15]}}, dw[15:0]} : {16'd0, dw[15:0]};
      default: mdout = dw;
    endcase
  end

  // Reference model state
  logic [7:0]  rm [512];
  logic [1:0]  m_v, m_e;
  logic [31:0] m_d [2];
  int          m_last;
  logic [1:0]  obs_g;
  logic        obs_wen;

  int tests = 0;
  int fails = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(logic [1:0] t);
    case (t)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(int a, int nb, logic sx);
    longint v = 0;
    for (int k = 0; k < nb; k++) v |= longint'(rm[a + k]) << (8 * k);
    if (sx && nb < 4 && v[8 * nb - 1]) v -= (longint'(1) << (8 * nb));
    return 32'(v);
  endfunction

  task automatic tick();
    logic [1:0]  el;
    int          eg, nb;
    longint      a;
    logic        e, wr;
    logic [31:0] d;
    #1;
    for (int p = 0; p < 2; p++) el[p] = rv[p] && (!m_v[p] || srdy[p]);
    if (!rst_n) el = 2'b00;
    if (el == 2'b11) eg = (m_last == 1) ? 0 : 1;
    else if (el[0]) eg = 0;
    else if (el[1]) eg = 1;
    else eg = -1;
    obs_g = {rdy1, rdy0};
    obs_wen = mwe;
    chk("ready0", 32'(rdy0), 32'(eg == 0));
    chk("ready1", 32'(rdy1), 32'(eg == 1));
    e = 1'b0; d = 32'd0; wr = 1'b0; nb = 0; a = 0;
    if (eg >= 0) begin
      nb = nbytes(rty[eg]);
      a = longint'(rad[eg]);
      if (nb == 0) e = 1'b1;
      else e = (a % nb != 0) || (a + nb > 512);
      if (!rwe[eg] && !e) d = exp_load(int'(a), nb, rsx[eg]);
      wr = rwe[eg] && !e;
    end
    chk("mem_we", 32'(mwe), 32'(wr));
    if (wr) for (int k = 0; k < nb; k++) rm[int'(a) + k] = 8'(rwd[eg] >> (8 * k));
    for (int p = 0; p < 2; p++) begin
      if (p == eg) begin
        m_v[p] = 1'b1; m_e[p] = e; m_d[p] = d;
      end else if (srdy[p]) begin
        m_v[p] = 1'b0;
      end
    end
    if (eg >= 0) m_last = eg;
    if (!rst_n) begin m_v = 2'b00; m_last = 1; end
    @(posedge clk); #1;
    chk("rsp_valid0", 32'(rspv0), 32'(m_v[0]));
    chk("rsp_valid1", 32'(rspv1), 32'(m_v[1]));
    if (m_v[0]) begin
      chk("rsp_rdata0", rd0, m_d[0]);
      chk("rsp_err0", 32'(er0), 32'(m_e[0]));
    end
    if (m_v[1]) begin
      chk("rsp_rdata1", rd1, m_d[1]);
      chk("rsp_err1", 32'(er1), 32'(m_e[1]));
    end
  endtask

  task automatic setreq(int p, logic we, logic [1:0] t, logic [31:0] a,
                        logic [31:0] d, logic sx);
    rv[p] = 1'b1; rwe[p] = we; rty[p] = t;
    rad[p] = a; rwd[p] = d; rsx[p] = sx;
  endtask

  logic [1:0]  t5_ty [5];
  logic [31:0] t5_ad [5];
  logic        t5_er [5];

  initial begin
    rst_n = 1'b0; init = 1'b1; rv = 2'b00; rwe = 2'b00; rsx = 2'b00;
    srdy = 2'b11;
    for (int p = 0; p < 2; p++) begin
      rty[p] = 2'b10; rad[p] = 32'd0; rwd[p] = 32'd0;
    end
    for (int i = 0; i < 512; i++) rm[i] = initb(i);
    m_v = 2'b00; m_e = 2'b00; m_d[0] = 32'd0; m_d[1] = 32'd0; m_last = 1;
    repeat (2) @(posedge clk);
    #1;
    init = 1'b0;
    setreq(0, 1'b1, 2'b10, 32'h10, 32'h1, 1'b0);
    #1;
    chk("rst_valid0", 32'(rspv0), 32'd0);
    chk("rst_valid1", 32'(rspv1), 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_err1", 32'(er1), 32'd0);
    chk("rst_ready0", 32'(rdy0), 32'd0);
    chk("rst_mwe", 32'(mwe), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; rv = 2'b00;

    // 1: store word then signed byte load of its top byte
    setreq(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
    tick();
    chk("t1_st_valid", 32'(rspv0), 32'd1);
    setreq(0, 1'b0, 2'b00, 32'h13, 32'h0, 1'b1);
    tick();
    chk("t1_rdata", rd0, 32'hFFFFFFDE);
    chk("t1_err", 32'(er0), 32'd0);
    rv = 2'b00;

    // 2: alternating grants starting with port 0
    setreq(1, 1'b0, 2'b10, 32'h20, 32'h0, 1'b0);
    tick();
    rv = 2'b00;
    tick();
    setreq(0, 1'b0, 2'b10, 32'h30, 32'h0, 1'b0);
    setreq(1, 1'b0, 2'b10, 32'h40, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t2_alt", 32'(obs_g), (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    // 3: port 1 backpressured, port 0 keeps going
    srdy[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_p0_only", 32'(obs_g), 32'd1);
      chk("t3_hold", rd1, initw(32'h40));
    end
    srdy[1] = 1'b1;
    tick();
    chk("t3_p1_back", 32'(obs_g), 32'd2);
    rv = 2'b00;

    // 4: misaligned store is rejected
    setreq(1, 1'b1, 2'b10, 32'h02, 32'h12345678, 1'b0);
    tick();
    chk("t4_wen", 32'(obs_wen), 32'd0);
    chk("t4_err", 32'(er1), 32'd1);
    chk("t4_rdata", rd1, 32'd0);
    setreq(1, 1'b0, 2'b10, 32'h00, 32'h0, 1'b0);
    tick();
    chk("t4_w0", rd1, initw(0));
    setreq(1, 1'b0, 2'b10, 32'h04, 32'h0, 1'b0);
    tick();
    chk("t4_w4", rd1, initw(4));
    rv = 2'b00;

    // 5: range and alignment boundaries
    t5_ty = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b10};
    t5_ad = '{32'h1FC, 32'h1FE, 32'h1FE, 32'h200, 32'hFFFFFFFC};
    t5_er = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      setreq(0, 1'b0, t5_ty[i], t5_ad[i], 32'h0, 1'b0);
      tick();
      chk("t5_err", 32'(er0), 32'(t5_er[i]));
    end
    rv = 2'b00;

    // 6: async reset mid-stream
    setreq(0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0);
    tick();
    chk("t6_pre", 32'(rspv0), 32'd1);
    rst_n = 1'b0;
    setreq(0, 1'b1, 2'b10, 32'h10, 32'hCAFEF00D, 1'b0);
    srdy[0] = 1'b0;
    #1;
    chk("t6_async", 32'(rspv0), 32'd0);
    chk("t6_ready", 32'(rdy0), 32'd0);
    chk("t6_mwe", 32'(mwe), 32'd0);
    tick();
    rst_n = 1'b1; srdy = 2'b11;
    setreq(0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0);
    setreq(1, 1'b0, 2'b10, 32'h14, 32'h0, 1'b0);
    tick();
    chk("t6_first", 32'(obs_g), 32'd1);
    chk("t6_nowrite", rd0, 32'hDEADBEEF);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        int r;
        rv[p]  = $urandom_range(0, 3) != 0;
        rwe[p] = $urandom_range(0, 2) == 0;
        rty[p] = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        rwd[p] = $urandom;
        rsx[p] = 1'($urandom_range(0, 1));
        srdy[p] = $urandom_range(0, 3) != 0;
        r = $urandom_range(0, 9);
        if (r == 0) rad[p] = $urandom;
        else if (r < 3) rad[p] = 32'(500 + $urandom_range(0, 15));
        else if (r < 7) rad[p] = 32'($urandom_range(0, 63)) & ~32'(nbytes(rty[p]) - 1);
        else rad[p] = 32'($urandom_range(0, 511));
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
